// File: rtl/wb_stage_if.sv
// Bus bundle between the memory stage and the write-back stage.
// With WB_RETIRE_CNT_EN defined, the bundle also carries retire_count.
interface wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              MEM_WB_EN_in;
  logic              MEM_R_EN_in;
  logic [3:0]        Dest_in;
  logic [DATA_W-1:0] ALU_Res_in;
  logic [DATA_W-1:0] MEM_Rdata;
  logic              MEM_Rdata_valid;
  logic              WB_WB_EN;
  logic [3:0]        WB_Dest;
  logic [DATA_W-1:0] WB_Value;
  logic              stall_req;
  logic              load_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]       retire_count;
`endif

  modport slave (
    input  MEM_WB_EN_in, MEM_R_EN_in, Dest_in, ALU_Res_in, MEM_Rdata, MEM_Rdata_valid,
    output WB_WB_EN, WB_Dest, WB_Value, stall_req, load_err
`ifdef WB_RETIRE_CNT_EN
    , output retire_count
`endif
  );

  modport master (
    output MEM_WB_EN_in, MEM_R_EN_in, Dest_in, ALU_Res_in, MEM_Rdata, MEM_Rdata_valid,
    input  WB_WB_EN, WB_Dest, WB_Value, stall_req, load_err
`ifdef WB_RETIRE_CNT_EN
    , input retire_count
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: captures ALU results in one cycle and waits for late load data,
// raising a sticky load_err on timeout. WB_RETIRE_CNT_EN adds a retired-write counter.
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int DATA_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, ERROR} state_e;

  localparam logic [7:0] TIMEOUT = 8'(LOAD_TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;
  logic              load_err_q, load_err_d;
  logic [3:0]        lat_dest_q, lat_dest_d;
  logic              lat_en_q, lat_en_d;
  logic              stall;

  // Control and architecturally visible outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_value_q <= wb_value_d;
      load_err_q <= load_err_d;
    end
  end

  // Destination of the pending load; only read in WAIT_LOAD, so no reset needed
  always_ff @(posedge clk) begin
    lat_dest_q <= lat_dest_d;
    lat_en_q   <= lat_en_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_en_d    = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_value_d = wb_value_q;
    load_err_d = load_err_q;
    lat_dest_d = lat_dest_q;
    lat_en_d   = lat_en_q;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MEM_R_EN_in && !bus.MEM_Rdata_valid) begin
          state_d    = WAIT_LOAD;
          cnt_d      = 8'd1;
          lat_dest_d = bus.Dest_in;
          lat_en_d   = bus.MEM_WB_EN_in;
          stall      = 1'b1;
        end else begin
          wb_en_d    = bus.MEM_WB_EN_in;
          wb_dest_d  = bus.Dest_in;
          wb_value_d = bus.MEM_R_EN_in ? bus.MEM_Rdata : bus.ALU_Res_in;
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the timeout cycle still completes the load
        if (bus.MEM_Rdata_valid) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_en_d    = lat_en_q;
          wb_dest_d  = lat_dest_q;
          wb_value_d = bus.MEM_Rdata;
        end else if (cnt_q >= TIMEOUT) begin
          state_d    = ERROR;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          stall = 1'b1;
        end
      end
      ERROR: begin
        load_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.stall_req = stall && !rst;
  assign bus.WB_WB_EN  = wb_en_q;
  assign bus.WB_Dest   = wb_dest_q;
  assign bus.WB_Value  = wb_value_q;
  assign bus.load_err  = load_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  assign retire_d = wb_en_d ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge clk) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign bus.retire_count = retire_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected write-backs are queued at issue time and
// matched against WB_* on the falling edge after each write.
module tb_wb_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_wr   = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wben, input logic ren, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic vld);
    bus.MEM_WB_EN_in    = wben;
    bus.MEM_R_EN_in     = ren;
    bus.Dest_in         = dest;
    bus.ALU_Res_in      = alu;
    bus.MEM_Rdata       = rdata;
    bus.MEM_Rdata_valid = vld;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic [3:0] dest, input logic [31:0] val);
    sb.push_back({dest, val});
    n_wr++;
  endtask

  // ALU op; valid/rdata are noise that must be ignored
  task automatic send_alu(input logic wben, input logic [3:0] dest, input logic [31:0] val);
    drive(wben, 1'b0, dest, val, $urandom, 1'($urandom_range(0, 1)));
    #1;
    chk("stall_alu", 32'(bus.stall_req), 32'd0);
    if (wben) push(dest, val);
    step();
    idle_inputs();
  endtask

  // Load whose data arrives after nstall stalled cycles (0 = same cycle)
  task automatic load_op(input logic wben, input logic [3:0] dest, input logic [31:0] data,
                         input int nstall);
    drive(wben, 1'b1, dest, $urandom, $urandom, 1'b0);
    for (int i = 0; i < nstall; i++) begin
      #1;
      chk("stall_wait", 32'(bus.stall_req), 32'd1);
      step();
      bus.MEM_Rdata = $urandom;
    end
    bus.MEM_Rdata       = data;
    bus.MEM_Rdata_valid = 1'b1;
    if (wben) push(dest, data);
    #1;
    chk("stall_done", 32'(bus.stall_req), 32'd0);
    step();
    idle_inputs();
  endtask

  always @(negedge clk) begin
    if (bus.WB_WB_EN === 1'b1) begin
      chk("wb_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [35:0] e;
        e = sb.pop_front();
        chk("wb_dest", 32'(bus.WB_Dest), 32'(e[35:32]));
        chk("wb_value", bus.WB_Value, e[31:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk("rst_wb_en", 32'(bus.WB_WB_EN), 32'd0);
    chk("rst_dest", 32'(bus.WB_Dest), 32'd0);
    chk("rst_value", bus.WB_Value, 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    drive(1'b1, 1'b1, 4'd2, 32'd0, 32'd0, 1'b0);
    #1;
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;

    send_alu(1'b1, 4'd3, 32'h0000_1234);
    load_op(1'b1, 4'd5, 32'hDEAD_BEEF, 0);
    load_op(1'b1, 4'd7, 32'hCAFE_0001, 3);
    load_op(1'b1, 4'd8, 32'h1357_9BDF, TO);
    send_alu(1'b0, 4'd9, 32'h0BAD_0BAD);
    chk("no_err_yet", 32'(bus.load_err), 32'd0);

    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       send_alu(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        1:       load_op(1'b1, 4'($urandom), $urandom, 0);
        2:       load_op(1'b1, 4'($urandom), $urandom, int'($urandom_range(1, TO)));
        default: load_op(1'b0, 4'($urandom), $urandom, 2);
      endcase
    end

    // Load that never gets data: TO stalled cycles, then ERROR
    drive(1'b1, 1'b1, 4'd9, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("stall_to", 32'(bus.stall_req), 32'd1);
      step();
    end
    #1;
    chk("stall_at_to", 32'(bus.stall_req), 32'd0);
    chk("err_before", 32'(bus.load_err), 32'd0);
    step();
    chk("err_set", 32'(bus.load_err), 32'd1);
    chk("err_stall", 32'(bus.stall_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 4'd1, 32'h55, 32'h66, 1'($urandom_range(0, 1)));
      step();
      chk("err_wb_en", 32'(bus.WB_WB_EN), 32'd0);
      chk("err_sticky", 32'(bus.load_err), 32'd1);
      chk("err_stall_hold", 32'(bus.stall_req), 32'd0);
    end
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    n_wr = 0;
    chk("err_rst_clear", 32'(bus.load_err), 32'd0);
    chk("err_rst_wb_en", 32'(bus.WB_WB_EN), 32'd0);

    // Reset on the second wait cycle after a nonzero write-back
    send_alu(1'b1, 4'd6, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(bus.stall_req), 32'd0);
    step();
    rst = 1'b0;
    n_wr = 0;
    idle_inputs();
    chk("mid_rst_wb_en", 32'(bus.WB_WB_EN), 32'd0);
    chk("mid_rst_dest", 32'(bus.WB_Dest), 32'd0);
    chk("mid_rst_value", bus.WB_Value, 32'd0);
    chk("mid_rst_err", 32'(bus.load_err), 32'd0);
    #1;
    chk("mid_rst_idle", 32'(bus.stall_req), 32'd0);
    send_alu(1'b1, 4'd4, 32'h0000_0077);

    for (int k = 0; k < 4; k++) send_alu(1'b1, 4'(k), 32'(k + 100));
    send_alu(1'b0, 4'd15, 32'hFFFF_FFFF);
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", bus.retire_count, 32'(n_wr));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
